// File: rtl/packet_switch_2x2_if.sv
// -----------------------------------------------------------------------------
// packet_switch_2x2_if
// Bundle of the four valid/ready streams around the 2x2 packet switch.
//   in1_* / in2_* : producer-side streams (valid, data, dest tag, ready)
//   out1_* / out2_*: consumer-side streams (valid, data, ready)
// Modports:
//   master : the environment (drives producer streams, consumer ready)
//   slave  : the switch itself
// -----------------------------------------------------------------------------
interface packet_switch_2x2_if #(
   parameter int WIDTH = 4
);
   logic             in1_valid;
   logic [WIDTH-1:0] in1_data;
   logic             in1_dest;
   logic             in1_ready;

   logic             in2_valid;
   logic [WIDTH-1:0] in2_data;
   logic             in2_dest;
   logic             in2_ready;

   logic             out1_valid;
   logic [WIDTH-1:0] out1_data;
   logic             out1_ready;

   logic             out2_valid;
   logic [WIDTH-1:0] out2_data;
   logic             out2_ready;

   modport master (
      output in1_valid, in1_data, in1_dest,
      input  in1_ready,
      output in2_valid, in2_data, in2_dest,
      input  in2_ready,
      input  out1_valid, out1_data,
      output out1_ready,
      input  out2_valid, out2_data,
      output out2_ready
   );

   modport slave (
      input  in1_valid, in1_data, in1_dest,
      output in1_ready,
      input  in2_valid, in2_data, in2_dest,
      output in2_ready,
      output out1_valid, out1_data,
      input  out1_ready,
      output out2_valid, out2_data,
      input  out2_ready
   );
endinterface

// File: rtl/packet_switch_2x2.sv
// -----------------------------------------------------------------------------
// packet_switch_2x2
// Buffered 2x2 packet switch. Each input owns a one-entry holding buffer, each
// output owns a registered stage. A packet's dest tag selects out1 (0) or
// out2 (1); when both buffers want the same output a per-output round-robin
// pointer chooses the winner and then points at the loser.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : packet_switch_2x2_if.slave - the in1/in2/out1/out2 streams
// -----------------------------------------------------------------------------
module packet_switch_2x2 #(
   parameter int WIDTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   packet_switch_2x2_if.slave  bus
);

   // Input holding buffers
   logic             buf1_valid_q, buf1_valid_d;
   logic [WIDTH-1:0] buf1_data_q,  buf1_data_d;
   logic             buf1_dest_q,  buf1_dest_d;
   logic             buf2_valid_q, buf2_valid_d;
   logic [WIDTH-1:0] buf2_data_q,  buf2_data_d;
   logic             buf2_dest_q,  buf2_dest_d;

   // Output stages
   logic             out1_valid_q, out1_valid_d;
   logic [WIDTH-1:0] out1_data_q,  out1_data_d;
   logic             out2_valid_q, out2_valid_d;
   logic [WIDTH-1:0] out2_data_q,  out2_data_d;

   // Round-robin pointers: 0 favours in1, 1 favours in2
   logic             prio1_q, prio1_d;
   logic             prio2_q, prio2_d;

   logic req1_o1, req2_o1, req1_o2, req2_o2;
   logic load1, load2;
   logic g1_o1, g2_o1, g1_o2, g2_o2;
   logic grant1, grant2;
   logic in1_ready, in2_ready;
   logic acc1, acc2;

   assign req1_o1 = buf1_valid_q && !buf1_dest_q;
   assign req2_o1 = buf2_valid_q && !buf2_dest_q;
   assign req1_o2 = buf1_valid_q &&  buf1_dest_q;
   assign req2_o2 = buf2_valid_q &&  buf2_dest_q;

   assign load1 = !out1_valid_q || bus.out1_ready;
   assign load2 = !out2_valid_q || bus.out2_ready;

   // A lone requester wins outright; on a conflict the pointer decides.
   assign g1_o1 = load1 && req1_o1 && (!req2_o1 || !prio1_q);
   assign g2_o1 = load1 && req2_o1 && (!req1_o1 ||  prio1_q);
   assign g1_o2 = load2 && req1_o2 && (!req2_o2 || !prio2_q);
   assign g2_o2 = load2 && req2_o2 && (!req1_o2 ||  prio2_q);

   assign grant1 = g1_o1 || g1_o2;
   assign grant2 = g2_o1 || g2_o2;

   // A buffer being drained this cycle can be refilled in the same cycle.
   assign in1_ready = !rst && (!buf1_valid_q || grant1);
   assign in2_ready = !rst && (!buf2_valid_q || grant2);

   assign acc1 = bus.in1_valid && in1_ready;
   assign acc2 = bus.in2_valid && in2_ready;

   always_comb begin
      buf1_valid_d = buf1_valid_q;
      buf1_data_d  = buf1_data_q;
      buf1_dest_d  = buf1_dest_q;
      buf2_valid_d = buf2_valid_q;
      buf2_data_d  = buf2_data_q;
      buf2_dest_d  = buf2_dest_q;
      out1_valid_d = out1_valid_q;
      out1_data_d  = out1_data_q;
      out2_valid_d = out2_valid_q;
      out2_data_d  = out2_data_q;
      prio1_d      = prio1_q;
      prio2_d      = prio2_q;

      if (acc1) begin
         buf1_valid_d = 1'b1;
         buf1_data_d  = bus.in1_data;
         buf1_dest_d  = bus.in1_dest;
      end else if (grant1) begin
         buf1_valid_d = 1'b0;
      end

      if (acc2) begin
         buf2_valid_d = 1'b1;
         buf2_data_d  = bus.in2_data;
         buf2_dest_d  = bus.in2_dest;
      end else if (grant2) begin
         buf2_valid_d = 1'b0;
      end

      if (g1_o1) begin
         out1_valid_d = 1'b1;
         out1_data_d  = buf1_data_q;
      end else if (g2_o1) begin
         out1_valid_d = 1'b1;
         out1_data_d  = buf2_data_q;
      end else if (bus.out1_ready) begin
         out1_valid_d = 1'b0;
      end

      if (g1_o2) begin
         out2_valid_d = 1'b1;
         out2_data_d  = buf1_data_q;
      end else if (g2_o2) begin
         out2_valid_d = 1'b1;
         out2_data_d  = buf2_data_q;
      end else if (bus.out2_ready) begin
         out2_valid_d = 1'b0;
      end

      // Pointer moves to the loser only when a real conflict was resolved.
      if (load1 && req1_o1 && req2_o1) prio1_d = !prio1_q;
      if (load2 && req1_o2 && req2_o2) prio2_d = !prio2_q;
   end

   // Control state and output data: cleared on reset
   always_ff @(posedge clk) begin
      if (rst) begin
         buf1_valid_q <= 1'b0;
         buf2_valid_q <= 1'b0;
         out1_valid_q <= 1'b0;
         out2_valid_q <= 1'b0;
         out1_data_q  <= '0;
         out2_data_q  <= '0;
         prio1_q      <= 1'b0;
         prio2_q      <= 1'b0;
      end else begin
         buf1_valid_q <= buf1_valid_d;
         buf2_valid_q <= buf2_valid_d;
         out1_valid_q <= out1_valid_d;
         out2_valid_q <= out2_valid_d;
         out1_data_q  <= out1_data_d;
         out2_data_q  <= out2_data_d;
         prio1_q      <= prio1_d;
         prio2_q      <= prio2_d;
      end
   end

   // Buffer payload is only meaningful while its valid bit is set
   always_ff @(posedge clk) begin
      buf1_data_q <= buf1_data_d;
      buf1_dest_q <= buf1_dest_d;
      buf2_data_q <= buf2_data_d;
      buf2_dest_q <= buf2_dest_d;
   end

   assign bus.in1_ready  = in1_ready;
   assign bus.in2_ready  = in2_ready;
   assign bus.out1_valid = out1_valid_q;
   assign bus.out1_data  = out1_data_q;
   assign bus.out2_valid = out2_valid_q;
   assign bus.out2_data  = out2_data_q;

endmodule

// File: doc/packet_switch_2x2.md
# packet_switch_2x2

Buffered 2x2 packet switch for 4-bit data with per-packet destination tags, valid/ready handshakes on all four ports, and round-robin arbitration on output conflict. Each input side has a one-entry holding buffer; each output side has a registered output stage. The block sits downstream of two 4-bit producers and upstream of two 4-bit consumers. Routing is decided per packet from its tag, so no static control line is needed.

## Interface
- WIDTH, 4, data bits per packet
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in1_valid  input  1  producer 1 offers a packet
- in1_data  input  WIDTH  producer 1 payload
- in1_dest  input  1  producer 1 destination: 0 = out1, 1 = out2
- in1_ready  output  1  switch accepts from producer 1 this cycle
- in2_valid / in2_data / in2_dest / in2_ready: same as port 1, for producer 2
- out1_valid  output  1  out1_data holds a packet
- out1_data  output  WIDTH  payload to consumer 1
- out1_ready  input  1  consumer 1 takes the packet this cycle
- out2_valid / out2_data / out2_ready: same as out1, for consumer 2

## Operation
- Transfer on any port occurs on a rising edge where valid && ready are both high.
- Input buffer i (i = 1, 2) holds buf_valid_i, buf_data_i and buf_dest_i.
- Output stage j (j = 1, 2) can load when load_en_j = !out_valid_j || out_ready_j.
- Requesters for output j: buffers with buf_valid = 1 and buf_dest selecting j.
- If exactly one buffer requests output j and load_en_j is high, that buffer is granted.
- If both request output j, prio_j picks the winner: prio_j = 0 grants in1, prio_j = 1 grants in2. On such a conflict grant, prio_j is set to point at the loser.
- prio_j changes only on a conflict grant.
- A buffer whose output has load_en low, or which lost arbitration, keeps its contents unchanged.
- Granted buffer to output j: out_data_j <= buf_data, out_valid_j <= 1, and the buffer empties unless refilled in the same cycle.
- Output j with out_ready_j high and no grant: out_valid_j <= 0. out_data_j holds its last value.
- in_i_ready = !rst && (!buf_valid_i || grant_i). This is combinational from state and out_ready, which allows one packet per cycle per input.
- Both buffers target different outputs: both are granted in the same cycle.
- Ordering: packets from a given input to a given output leave in acceptance order. No packet is dropped or duplicated.

## Timing
- Reset values: out1_valid = out2_valid = 0; out1_data = out2_data = 0; buffers empty; prio_1 = prio_2 = 0; in1_ready = in2_ready = 0 while rst = 1.
- The cycle after rst deasserts, in1_ready = in2_ready = 1.
- Latency: a packet accepted at edge k is visible at the output after edge k+1, provided its output was loadable and it won arbitration.
- Throughput: one packet per cycle per output under continuous out_ready.
- Stability: while out_valid_j && !out_ready_j, out_data_j and out_valid_j are held.
- Conflict: the losing input stalls with in_ready low for exactly one cycle, given out_ready held high.
- Reset mid-operation: all buffered and output packets are discarded at the reset edge. No stale data appears after release.

## Test plan
- Reset: hold rst for 2 cycles with in1_valid = 1, in1_data = 4'hF -> in_ready = 0, out_valid = 0, out_data = 0 throughout. After release: in_ready = 1 and nothing is emitted.
- Straight and cross routing, both out_ready = 1. in1 = 4'hA/dest 0 with in2 = 4'h5/dest 1 -> one cycle later out1 = A, out2 = 5. Next in1 = 4'h3/dest 1 with in2 = 4'hC/dest 0 -> out2 = 3, out1 = C.
- Conflict round-robin: in1 = 4'h1 and in2 = 4'h2, both dest 0 -> out1 shows 1 then 2 on consecutive cycles, with in2_ready low for one cycle. Then 4'h3 (in1) and 4'h4 (in2), both dest 0 -> 4 then 3.
- Backpressure: stream 4'h6, 4'h7, 4'h8 from in1 to dest 0 with out1_ready = 0 for 5 cycles -> out1_data = 6 stable with out1_valid = 1, and in1_ready = 0 once the buffer holds 7. After release: 6, 7, 8 in order, with no loss.
- Independent stall: out1_ready = 0 while in2 streams to out2 -> out2 traffic flows at full rate, unaffected.
- Mid-operation reset: both buffers and outputs full, assert rst for 1 cycle -> all out_valid = 0 and data = 0. No old packet emitted afterwards, and prio resets to 0 (verified by the next conflict granting in1).
